// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: op codes, FSM state encoding, default datapath width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of alu_arbiter; slave is the arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2:0]       req0_ctl;
  logic [2:0]       req1_ctl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [2:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_ready;

  modport slave (
    input  req_valid, req0_ctl, req1_ctl, req0_a, req0_b, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_ctl, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req_valid, req0_ctl, req1_ctl, req0_a, req0_b, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_ctl, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last winner loses the next tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_enable,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Resetting to 1 hands the very first tie to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: one operation in flight,
// operands held in registers on alu_*, result returned through a registered response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  state_e           r_state;
  logic [2:0]       r_ctl;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic [1:0]       w_grant;
  logic             w_enable;
  logic             w_accept;

  // NOTE: rst_n gates the grant combinationally so req_ready is low for the whole reset, not just after the first edge.
  assign w_enable = (r_state == ST_IDLE) && rst_n;
  assign w_accept = |(bus.req_valid & w_grant);

  rr_arbiter2 u_rr_arbiter2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (bus.req_valid),
    .i_enable (w_enable),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ctl        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_grant[1];
            r_ctl   <= w_grant[1] ? bus.req1_ctl : bus.req0_ctl;
            r_a     <= w_grant[1] ? bus.req1_a   : bus.req0_a;
            r_b     <= w_grant[1] ? bus.req1_b   : bus.req0_b;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= bus.alu_result;
          r_rsp_zero   <= bus.alu_zero;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The ALU sees the operand registers at all times, so it only toggles on acceptance.
  assign bus.req_ready  = w_grant;
  assign bus.alu_ctl    = r_ctl;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;

endmodule
